mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer placed in front of the shared data memory model. It accepts read/write requests from the fetch port (port 0) and the load/store port (port 1), and launches exactly one memory transaction at a time, aligned to the memory's idle/busy/done status cycle. It returns the completion to the owning port and guarantees that no spurious write is ever replayed.

## Interface
- LATENCY, default 1: memory's internal latency_cycles value; used only by the bench to check the 4-cycle cadence at the default; the RTL relies on mem_status alone.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- p0_req / p1_req  in  1  request valid; held with its fields until the matching gnt.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  32  byte address.
- p0_wdata / p1_wdata  in  32  write data.
- p0_gnt / p1_gnt  out  1  one-cycle acceptance pulse; the request is consumed at this edge.
- p0_rvalid / p1_rvalid  out  1  one-cycle completion pulse; it also serves as the write acknowledge.
- p0_rdata / p1_rdata  out  32  read data, valid while the matching rvalid is high; ignore it for writes.
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  32  memory address (registered).
- mem_wdata  out  32  memory write data (registered).
- mem_rdata  in  32  memory read data.
- mem_status  in  2  memory status: 00 idle, 01 busy, 10 done.
- busy  out  1  high while a transaction is in flight (state BUSY).

## Operation
- States:
  - IDLE: no transaction owned; mem_we is held at 0, so the memory runs harmless dummy reads.
  - BUSY: a transaction is launched and owned by port `owner`.
- IDLE → BUSY: taken when mem_status==00 and at least one req is high.
  - Pick a winner. gnt[winner]=1 combinationally in that cycle.
  - At the edge: load mem_we/mem_addr/mem_wdata from the winner, set owner, and flip the round-robin pointer away from the winner.
- If a req is high in IDLE but mem_status is 01 or 10, do not grant; wait for 00. This ensures the memory samples the loaded fields at its completion edge.
- In IDLE, ignore a mem_status==10 caused by a dummy transaction.
- BUSY, mem_status==10:
  - rvalid[owner]=1 combinationally; rdata[owner]=mem_rdata.
  - At the edge: state → IDLE and mem_we → 0. The write must not repeat.
  - mem_addr/mem_wdata keep their values.
- BUSY, mem_status 00/01: hold everything.
- Arbitration:
  - Only one port requesting: that port wins.
  - Both requesting: the port the round-robin pointer favours wins.
  - The pointer reset value favours port 0.
- p*_rdata is mem_rdata for both ports; only rvalid is qualified.
- Reset values, applied immediately on reset assertion:
  - state=IDLE; pointer favours port 0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - All gnt, rvalid and busy = 0.
- Reset mid-transaction: the transaction is silently dropped and no rvalid is issued. Requesters re-issue after reset.

## Timing
- Grant in cycle n (mem_status==00):
  - n+1 .. n+LATENCY+1: mem_status==01.
  - n+LATENCY+2: mem_status==10 and rvalid.
  - n+LATENCY+3: mem_status==00; the next grant is possible.
- With LATENCY=1: grant→rvalid is 3 cycles; back-to-back transactions start every 4 cycles.
- A request arriving while mem_status==01 (dummy in progress) waits until the next 00 cycle.
- A new gnt never coincides with an rvalid; they are at least one cycle apart.

## Configuration
- MEM_ARB_FIXED_PRIO_EN:
  - Defined: port 1 (load/store) always wins simultaneous requests; the round-robin pointer is not built.
  - Undefined (default): round-robin alternation as above.

## Structure
- Package mem_arb_pkg holds:
  - mem_status_e: MEM_IDLE=2'b00, MEM_BUSY=2'b01, MEM_DONE=2'b10.
  - arb_state_e: IDLE, BUSY.
  - Port index constants PORT_FETCH=0, PORT_LSU=1.
- Sub-module rr_arb2: two-request picker that keeps the pointer; it reduces to fixed priority under the macro.

## Test plan
- Port 0 reads 0x100 (memory holds 0xDEADBEEF) with LATENCY=1 → p0_gnt in cycle n, p0_rvalid in cycle n+3 with p0_rdata=0xDEADBEEF, busy high n+1..n+3.
- Port 1 writes 0x55AA to 0x200, then port 0 reads 0x200 → exactly one mm_write is observed; the read returns 0x55AA; mem_we is 0 from the cycle after the write's rvalid.
- Both ports request continuously from reset (default build) → grant order 0,1,0,1 at 4-cycle spacing.
- Both ports request continuously with MEM_ARB_FIXED_PRIO_EN → grants go only to port 1 while p1_req is held.
- Request raised while mem_status==01 → no gnt until the first cycle with mem_status==00, then normal 3-cycle completion.
- Assert reset one cycle after a port 1 write grant → all outputs 0 at once, no p1_rvalid; after reset release the port re-requests and completes normally.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-port memory arbiter.
//   mem_status_e : status code reported by the shared data memory model
//   arb_state_e  : arbiter sequencer state
//   PORT_FETCH / PORT_LSU : requester indices (fetch = 0, load/store = 1)
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'b00,
    MEM_BUSY = 2'b01,
    MEM_DONE = 2'b10
  } mem_status_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int unsigned PORT_FETCH = 0;
  localparam int unsigned PORT_LSU   = 1;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-request picker used by mem_arbiter.
//   clk       : clock
//   rst       : asynchronous active-high reset
//   i_req     : request vector, bit 0 = fetch port, bit 1 = load/store port
//   i_accept  : the current pick is being consumed this cycle
//   o_gnt     : one-hot pick (all zero when nothing requests)
//   o_winner  : index of the picked port
// Build option: MEM_ARB_FIXED_PRIO_EN -- when defined, port 1 always wins a
// tie and no pointer state exists; otherwise ties alternate round-robin.
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt,
  output logic       o_winner
);

  logic w_pick1;

`ifdef MEM_ARB_FIXED_PRIO_EN
  // Load/store port is always preferred; the clock, reset and accept inputs
  // have nothing to drive in this build.
  logic w_unused_ctrl;
  assign w_unused_ctrl = clk ^ rst ^ i_accept;

  assign w_pick1 = i_req[1];
`else
  // r_prio = 0 favours port 0, r_prio = 1 favours port 1.
  logic r_prio;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio <= 1'b0;
    end else if (i_accept) begin
      // Point away from whoever just won.
      r_prio <= ~o_winner;
    end
  end

  assign w_pick1 = i_req[1] & (~i_req[0] | r_prio);
`endif

  assign o_winner = w_pick1;
  assign o_gnt    = {w_pick1, i_req[0] & ~w_pick1};

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Arbitrates read/write requests from the fetch port (p0) and the load/store
// port (p1) onto a shared memory that cycles idle -> busy -> done. Exactly one
// transaction is launched at a time, and only in a cycle where the memory
// reports idle, so the registered mem_* fields are sampled by the memory at
// the completion edge of that transaction.
//
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   pN_req/we/addr/wdata      : request from port N, held until pN_gnt
//   pN_gnt                    : one-cycle acceptance pulse
//   pN_rvalid / pN_rdata      : one-cycle completion pulse / read data
//   mem_we/addr/wdata         : registered memory command
//   mem_rdata, mem_status     : memory read data and status (00/01/10)
//   busy                      : a transaction is in flight
// Parameter LATENCY documents the memory latency only; the sequencing is
// driven purely by mem_status.
// Build option: MEM_ARB_FIXED_PRIO_EN (see rr_arb2).
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                p0_req,
  input  logic                p0_we,
  input  logic [ADDR_W-1:0]   p0_addr,
  input  logic [DATA_W-1:0]   p0_wdata,
  input  logic                p1_req,
  input  logic                p1_we,
  input  logic [ADDR_W-1:0]   p1_addr,
  input  logic [DATA_W-1:0]   p1_wdata,
  output logic                p0_gnt,
  output logic                p1_gnt,
  output logic                p0_rvalid,
  output logic                p1_rvalid,
  output logic [DATA_W-1:0]   p0_rdata,
  output logic [DATA_W-1:0]   p1_rdata,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic [1:0]          mem_status,
  output logic                busy
);

  logic [31:0] w_unused_latency;
  assign w_unused_latency = LATENCY;

  arb_state_e        r_state;
  arb_state_e        w_state_next;
  logic              r_owner;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  mem_status_e       w_status;
  logic [1:0]        w_req;
  logic [1:0]        w_arb_gnt;
  logic              w_winner;
  logic              w_launch;
  logic              w_done;
  logic              w_sel_we;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;

  assign w_status = mem_status_e'(mem_status);
  assign w_req    = {p1_req, p0_req};

  rr_arb2 u_rr_arb2 (
    .clk      (clk),
    .rst      (reset),
    .i_req    (w_req),
    .i_accept (w_launch),
    .o_gnt    (w_arb_gnt),
    .o_winner (w_winner)
  );

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_launch     = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        // Launch only on an idle memory cycle; a done status here belongs to
        // a dummy read and is ignored. The reset term keeps gnt low while
        // reset is asserted even though the state is already IDLE.
        if (!reset && (w_status == MEM_IDLE) && (|w_req)) begin
          w_launch     = 1'b1;
          w_state_next = BUSY;
        end
      end
      BUSY: begin
        if (w_status == MEM_DONE) begin
          w_done       = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Memory command registers
  // ---------------------------------------------------------------------------
  assign w_sel_we    = w_winner ? p1_we    : p0_we;
  assign w_sel_addr  = w_winner ? p1_addr  : p0_addr;
  assign w_sel_wdata = w_winner ? p1_wdata : p0_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_owner     <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_launch) begin
      r_owner     <= w_winner;
      r_mem_we    <= w_sel_we;
      r_mem_addr  <= w_sel_addr;
      r_mem_wdata <= w_sel_wdata;
    end else if (w_done) begin
      // Drop the write enable at completion so the memory's next (dummy)
      // cycle can never replay the write. Address/data stay as they were.
      r_mem_we <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign p0_gnt    = w_launch & w_arb_gnt[0];
  assign p1_gnt    = w_launch & w_arb_gnt[1];
  assign p0_rvalid = w_done & ~r_owner;
  assign p1_rvalid = w_done &  r_owner;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = (r_state == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with a small behavioural memory that cycles
// idle (1) -> busy (LATENCY+1) -> done (1) forever and commits a write at the
// edge that ends its done cycle.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int LATENCY = 1;
  localparam int DONE_PH = LATENCY + 2;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic        p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [31:0] p0_rdata, p1_rdata;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_status;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.LATENCY(LATENCY)) dut (
    .clk        (clk),
    .reset      (reset),
    .p0_req     (p0_req),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p0_gnt     (p0_gnt),
    .p1_gnt     (p1_gnt),
    .p0_rvalid  (p0_rvalid),
    .p1_rvalid  (p1_rvalid),
    .p0_rdata   (p0_rdata),
    .p1_rdata   (p1_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_status (mem_status),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [31:0] mem [0:1023];
  int phase;
  int wr_count = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      phase   <= 0;
      mem[64] <= 32'hDEADBEEF;  // word at byte address 0x100
    end else begin
      if (phase == DONE_PH && mem_we) begin
        mem[mem_addr[11:2]] <= mem_wdata;
        wr_count            <= wr_count + 1;
      end
      phase <= (phase == DONE_PH) ? 0 : phase + 1;
    end
  end

  always_comb begin
    mem_status = 2'b10;
    if (phase == 0)                 mem_status = 2'b00;
    else if (phase <= LATENCY + 1)  mem_status = 2'b01;
    mem_rdata = mem[mem_addr[11:2]];
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the given port's grant; returns at the grant cycle.
  task automatic wait_gnt(input int port, input string tag);
    logic seen;
    seen = 1'b0;
    #1;
    for (int i = 0; i < 20; i++) begin
      if ((port == 0) ? p0_gnt : p1_gnt) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    chk1({tag, " gnt seen"}, seen, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int g_port [0:7];
  int g_cyc  [0:7];
  int ng;
  int k;

  initial begin
    reset    = 1'b1;
    p0_req   = 1'b1;  // held during reset: must not produce a grant
    p0_we    = 1'b0;
    p0_addr  = 32'h100;
    p0_wdata = 32'h0;
    p1_req   = 1'b0;
    p1_we    = 1'b0;
    p1_addr  = 32'h0;
    p1_wdata = 32'h0;
    step();
    step();

    // ---- reset state ----
    chk1 ("rst p0_gnt",    p0_gnt,    1'b0);
    chk1 ("rst p1_gnt",    p1_gnt,    1'b0);
    chk1 ("rst p0_rvalid", p0_rvalid, 1'b0);
    chk1 ("rst p1_rvalid", p1_rvalid, 1'b0);
    chk1 ("rst busy",      busy,      1'b0);
    chk1 ("rst mem_we",    mem_we,    1'b0);
    chk32("rst mem_addr",  mem_addr,  32'h0);
    chk32("rst mem_wdata", mem_wdata, 32'h0);
    $display("reset: outputs checked");

    p0_req = 1'b0;
    reset  = 1'b0;
    step();

    // ---- T1: port 0 reads 0x100 ----
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h100;
    wait_gnt(0, "t1");
    chk32("t1 status at gnt", 32'(mem_status), 32'h0);
    chk1 ("t1 busy at gnt",   busy,   1'b0);
    chk1 ("t1 p1_gnt",        p1_gnt, 1'b0);
    step(); p0_req = 1'b0;
    chk1 ("t1 busy n+1",      busy,      1'b1);
    chk32("t1 mem_addr",      mem_addr,  32'h100);
    chk1 ("t1 mem_we",        mem_we,    1'b0);
    chk1 ("t1 rvalid n+1",    p0_rvalid, 1'b0);
    step();
    chk1 ("t1 busy n+2",      busy,      1'b1);
    chk1 ("t1 rvalid n+2",    p0_rvalid, 1'b0);
    step();
    chk1 ("t1 rvalid n+3",    p0_rvalid, 1'b1);
    chk32("t1 rdata",         p0_rdata,  32'hDEADBEEF);
    chk1 ("t1 p1_rvalid",     p1_rvalid, 1'b0);
    chk1 ("t1 busy n+3",      busy,      1'b1);
    step();
    chk1 ("t1 busy n+4",      busy,      1'b0);
    chk1 ("t1 rvalid n+4",    p0_rvalid, 1'b0);
    $display("t1: p0 read 0x100 -> %h", 32'hDEADBEEF);

    // ---- T2: port 1 writes 0x55AA to 0x200, then port 0 reads it ----
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h200; p1_wdata = 32'h55AA;
    wait_gnt(1, "t2w");
    step(); p1_req = 1'b0;
    chk1 ("t2w mem_we",       mem_we,    1'b1);
    chk32("t2w mem_addr",     mem_addr,  32'h200);
    chk32("t2w mem_wdata",    mem_wdata, 32'h55AA);
    step();
    step();
    chk1 ("t2w p1_rvalid",    p1_rvalid, 1'b1);
    chk1 ("t2w p0_rvalid",    p0_rvalid, 1'b0);
    step();
    chk1 ("t2w mem_we after", mem_we,    1'b0);
    chk32("t2w wr_count",     32'(wr_count), 32'd1);
    $display("t2: p1 write 0x200 <= %h", 32'h55AA);

    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h200;
    wait_gnt(0, "t2r");
    step(); p0_req = 1'b0;
    step();
    step();
    chk1 ("t2r p0_rvalid",    p0_rvalid, 1'b1);
    chk32("t2r rdata",        p0_rdata,  32'h55AA);
    for (int i = 0; i < 5; i++) step();
    chk32("t2r no replay",    32'(wr_count), 32'd1);
    chk32("t2r mem_addr kept", mem_addr, 32'h200);
    $display("t2: p0 read 0x200 -> %h", 32'h55AA);

    // ---- T3: both ports request continuously from reset ----
    reset = 1'b1;
    step();
    reset  = 1'b0;
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h100;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h200;
    #1;
    ng = 0;
    for (int c = 0; c < 16; c++) begin
      if (p0_gnt || p1_gnt) begin
        chk1("t3 single gnt",        p0_gnt & p1_gnt, 1'b0);
        chk1("t3 gnt without rvalid", p0_rvalid | p1_rvalid, 1'b0);
        if (ng < 8) begin
          g_port[ng] = p1_gnt ? 1 : 0;
          g_cyc[ng]  = c;
        end
        ng++;
      end
      step();
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    chk32("t3 grant count", 32'(ng), 32'd4);
    for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
      chk32("t3 grant port", 32'(g_port[i]), 32'd1);
`else
      chk32("t3 grant port", 32'(g_port[i]), 32'(i % 2));
`endif
      chk32("t3 grant cycle", 32'(g_cyc[i]), 32'(4 * i));
      $display("t3: grant %0d -> port %0d at cycle %0d", i, g_port[i], g_cyc[i]);
    end

    // ---- T4: request raised during a dummy busy phase ----
    k = 0;
    while (phase != 1 && k < 10) begin
      step();
      k++;
    end
    chk32("t4 reached busy", 32'(mem_status), 32'h1);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h100;
    #1;
    chk1("t4 no gnt busy1",  p0_gnt, 1'b0);
    step();
    chk1("t4 no gnt busy2",  p0_gnt, 1'b0);
    step();
    chk1("t4 no gnt done",   p0_gnt, 1'b0);
    chk1("t4 dummy no rvalid", p0_rvalid, 1'b0);
    step();
    chk1 ("t4 gnt at idle",  p0_gnt, 1'b1);
    chk32("t4 status idle",  32'(mem_status), 32'h0);
    step(); p0_req = 1'b0;
    step();
    step();
    chk1 ("t4 rvalid",       p0_rvalid, 1'b1);
    chk32("t4 rdata",        p0_rdata,  32'hDEADBEEF);
    step();
    $display("t4: late request granted on first idle cycle");

    // ---- T5: reset one cycle after a port 1 write grant ----
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 32'h300; p1_wdata = 32'h1234;
    wait_gnt(1, "t5");
    step();
    chk1("t5 mem_we pre-reset", mem_we, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk1 ("t5 rst mem_we",    mem_we,    1'b0);
    chk32("t5 rst mem_addr",  mem_addr,  32'h0);
    chk32("t5 rst mem_wdata", mem_wdata, 32'h0);
    chk1 ("t5 rst busy",      busy,      1'b0);
    chk1 ("t5 rst p1_gnt",    p1_gnt,    1'b0);
    chk1 ("t5 rst p1_rvalid", p1_rvalid, 1'b0);
    step();
    chk1 ("t5 rst hold rvalid", p1_rvalid, 1'b0);
    step();
    chk32("t5 write dropped", 32'(wr_count), 32'd1);
    reset = 1'b0;
    wait_gnt(1, "t5 reissue");
    step(); p1_req = 1'b0;
    chk1 ("t5 re mem_we",     mem_we,   1'b1);
    chk32("t5 re mem_addr",   mem_addr, 32'h300);
    step();
    step();
    chk1 ("t5 re p1_rvalid",  p1_rvalid, 1'b1);
    step();
    chk32("t5 re wr_count",   32'(wr_count), 32'd2);
    chk32("t5 re mem word",   mem[192], 32'h1234);
    chk1 ("t5 re mem_we off", mem_we, 1'b0);
    $display("t5: write dropped by reset, re-issued write 0x300 <= %h", 32'h1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
